bus_handshakes_reg_slice: RTL and testbench

- Parametrised valid/ready register slice for the bus-handshake path.
- Sits between a source and a destination, like the existing forward-registered stage.
- MODE selects one of four structures at elaboration:
  - combinational pass-through;
  - forward-registered (valid/data);
  - backward-registered (ready);
  - fully registered two-entry skid.
- Adds a synchronous flush and an occupancy output, which the existing stage does not have.

---
 rtl/bus_handshakes_reg_slice.sv | 138 +++++++++++++
 tb/tb_bus_handshakes_reg_slice.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_handshakes_reg_slice.sv
// Valid/ready register slice with a structure chosen at elaboration: pass-through,
// forward-registered, backward-registered (skid), or fully registered two-entry buffer.
module bus_handshakes_reg_slice #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned MODE  = 3
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             flush,
    input  logic             src_vaild,
    input  logic [WIDTH-1:0] src_data_in,
    output logic             src_ready,
    output logic             dst_vaild,
    output logic [WIDTH-1:0] dst_data_out,
    input  logic             dst_ready,
    output logic [1:0]       level
);

    localparam int unsigned ModeEff = (MODE > 32'd3) ? 32'd3 : MODE;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    logic             w_out_valid_nxt;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic             w_skid_valid_nxt;
    logic [WIDTH-1:0] w_skid_data_nxt;

    logic             w_block;
    logic             w_src_ready;
    logic             w_dst_valid;
    logic [WIDTH-1:0] w_dst_data;
    logic             w_in;
    logic             w_out;

    assign w_block = s_rst | flush;

    // In modes 2 and 3 the skid register is only ever full when the slice cannot
    // take another beat, so its inverse is the registered ready.
    always_comb begin
        w_src_ready = 1'b0;
        w_dst_valid = 1'b0;
        w_dst_data  = '0;
        case (ModeEff)
            0: begin
                w_src_ready = dst_ready;
                w_dst_valid = src_vaild;
                w_dst_data  = src_data_in;
            end
            1: begin
                w_src_ready = ~r_out_valid | dst_ready;
                w_dst_valid = r_out_valid;
                w_dst_data  = r_out_data;
            end
            2: begin
                w_src_ready = ~r_skid_valid;
                w_dst_valid = r_skid_valid | src_vaild;
                w_dst_data  = r_skid_valid ? r_skid_data : src_data_in;
            end
            default: begin
                w_src_ready = ~r_skid_valid;
                w_dst_valid = r_out_valid;
                w_dst_data  = r_out_data;
            end
        endcase
    end

    assign src_ready    = w_src_ready & ~w_block;
    assign dst_vaild    = w_dst_valid & ~w_block;
    assign dst_data_out = s_rst ? '0 : w_dst_data;
    assign level        = s_rst ? 2'd0 : ({1'b0, r_out_valid} + {1'b0, r_skid_valid});

    assign w_in  = src_vaild & src_ready;
    assign w_out = dst_vaild & dst_ready;

    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        case (ModeEff)
            0: begin
            end
            1: begin
                if (src_ready) begin
                    w_out_valid_nxt = w_in;
                    if (w_in) begin
                        w_out_data_nxt = src_data_in;
                    end
                end
            end
            2: begin
                if (r_skid_valid) begin
                    if (w_out) begin
                        w_skid_valid_nxt = 1'b0;
                    end
                end else if (w_in && !dst_ready) begin
                    w_skid_valid_nxt = 1'b1;
                    w_skid_data_nxt  = src_data_in;
                end
            end
            default: begin
                // Output register refills from the skid first so order is preserved.
                if (!r_out_valid || w_out) begin
                    if (r_skid_valid) begin
                        w_out_data_nxt   = r_skid_data;
                        w_skid_valid_nxt = 1'b0;
                    end else begin
                        w_out_valid_nxt = w_in;
                        if (w_in) begin
                            w_out_data_nxt = src_data_in;
                        end
                    end
                end else if (w_in) begin
                    w_skid_valid_nxt = 1'b1;
                    w_skid_data_nxt  = src_data_in;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_block) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
        end
    end

endmodule

// File: tb/tb_bus_handshakes_reg_slice.sv
// Bench for all four slice structures: directed scenarios plus random traffic, checked
// against a beat-queue model of what the slice holds.
module tb_bus_handshakes_reg_slice;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst   [4];
    logic         flush [4];
    logic         sv    [4];
    logic [W-1:0] sd    [4];
    logic         srdy  [4];
    logic         dv    [4];
    logic [W-1:0] dd    [4];
    logic         dr    [4];
    logic [1:0]   lvl   [4];

    int           n_assert = 0;
    int           n_fail   = 0;
    int           n_recv   = 0;
    logic [W-1:0] mq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bus_handshakes_reg_slice #(
            .WIDTH(W),
            .MODE (g)
        ) u_dut (
            .clk         (clk),
            .s_rst       (rst[g]),
            .flush       (flush[g]),
            .src_vaild   (sv[g]),
            .src_data_in (sd[g]),
            .src_ready   (srdy[g]),
            .dst_vaild   (dv[g]),
            .dst_data_out(dd[g]),
            .dst_ready   (dr[g]),
            .level       (lvl[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle starting at a falling edge: drive, check against the queue, advance.
    task automatic step(input int m, input logic v, input logic [W-1:0] d, input logic r,
                        output logic acc);
        logic         exp_rdy;
        logic         exp_v;
        logic [W-1:0] exp_d;
        sv[m] = v;
        sd[m] = d;
        dr[m] = r;
        #1;
        case (m)
            0:       exp_rdy = r;
            1:       exp_rdy = (mq.size() == 0) || r;
            2:       exp_rdy = (mq.size() == 0);
            default: exp_rdy = (mq.size() < 2);
        endcase
        exp_v = (m == 0 || m == 2) ? (mq.size() > 0 || v) : (mq.size() > 0);
        exp_d = (mq.size() > 0) ? mq[0] : d;
        check($sformatf("m%0d src_ready", m), 32'(srdy[m]), 32'(exp_rdy));
        check($sformatf("m%0d dst_vaild", m), 32'(dv[m]), 32'(exp_v));
        check($sformatf("m%0d level", m), 32'(lvl[m]), 32'(mq.size()));
        if (exp_v) check($sformatf("m%0d dst_data_out", m), 32'(dd[m]), 32'(exp_d));
        acc = v && exp_rdy;
        if (acc) mq.push_back(d);
        if (exp_v && r) begin
            void'(mq.pop_front());
            n_recv++;
        end
        @(negedge clk);
    endtask

    task automatic ctl_cycle(input int m, input logic is_flush);
        sv[m] = 1'b1;
        sd[m] = W'($urandom);
        dr[m] = 1'b1;
        if (is_flush) flush[m] = 1'b1;
        else rst[m] = 1'b1;
        #1;
        check($sformatf("m%0d blk src_ready", m), 32'(srdy[m]), 32'd0);
        check($sformatf("m%0d blk dst_vaild", m), 32'(dv[m]), 32'd0);
        if (!is_flush) begin
            check($sformatf("m%0d rst dst_data_out", m), 32'(dd[m]), 32'd0);
            check($sformatf("m%0d rst level", m), 32'(lvl[m]), 32'd0);
        end
        mq.delete();
        @(negedge clk);
        flush[m] = 1'b0;
        rst[m]   = 1'b0;
    endtask

    initial begin
        logic acc;
        int   nxt;
        int   hold;
        int   cyc;
        logic r;
        int   k;

        for (int i = 0; i < 4; i++) begin
            rst[i]   = 1'b1;
            flush[i] = 1'b0;
            sv[i]    = 1'b1;
            sd[i]    = W'(i * 37 + 5);
            dr[i]    = 1'b1;
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("m%0d init src_ready", i), 32'(srdy[i]), 32'd0);
            check($sformatf("m%0d init dst_vaild", i), 32'(dv[i]), 32'd0);
            check($sformatf("m%0d init dst_data_out", i), 32'(dd[i]), 32'd0);
            check($sformatf("m%0d init level", i), 32'(lvl[i]), 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b0;
            sv[i]  = 1'b0;
        end

        // Mode 3 streaming 0x001..0x00A with continuous ready.
        for (int i = 1; i <= 10; i++) step(3, 1'b1, W'(i), 1'b1, acc);
        step(3, 1'b0, '0, 1'b1, acc);
        step(3, 1'b0, '0, 1'b1, acc);

        // Mode 3 fill to two entries, then drain in order.
        step(3, 1'b1, 9'h0A5, 1'b0, acc);
        step(3, 1'b1, 9'h15A, 1'b0, acc);
        step(3, 1'b1, 9'h077, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(3, 1'b0, '0, 1'b1, acc);

        // Mode 3 flush at two entries; 0x1FF must be the first beat delivered after.
        step(3, 1'b1, 9'h011, 1'b0, acc);
        step(3, 1'b1, 9'h022, 1'b0, acc);
        ctl_cycle(3, 1'b1);
        step(3, 1'b1, 9'h1FF, 1'b0, acc);
        step(3, 1'b0, '0, 1'b1, acc);
        step(3, 1'b0, '0, 1'b1, acc);

        // Mode 2 skid capture under stall.
        step(2, 1'b1, 9'h033, 1'b0, acc);
        step(2, 1'b1, 9'h044, 1'b0, acc);
        step(2, 1'b1, 9'h044, 1'b1, acc);
        step(2, 1'b1, 9'h044, 1'b1, acc);
        step(2, 1'b0, '0, 1'b1, acc);

        // Mode 1: 256 incrementing beats, ready toggling with 20..300 ns holds.
        n_recv = 0;
        nxt    = 0;
        hold   = 0;
        cyc    = 0;
        r      = 1'b0;
        while (n_recv < 256 && cyc < 5000) begin
            if (hold == 0) begin
                r    = ~r;
                hold = $urandom_range(2, 30);
            end
            hold--;
            step(1, nxt < 256, W'(nxt), r, acc);
            if (acc) nxt++;
            cyc++;
        end
        check("m1 beats delivered", 32'(n_recv), 32'd256);
        check("m1 queue drained", 32'(mq.size()), 32'd0);

        // Reset mid-stream with one beat held, in every mode.
        for (int m = 0; m < 4; m++) begin
            step(m, 1'b1, 9'h0C3, 1'b0, acc);
            step(m, 1'b0, '0, 1'b0, acc);
            ctl_cycle(m, 1'b0);
            step(m, 1'b1, 9'h05A, 1'b1, acc);
            step(m, 1'b0, '0, 1'b1, acc);
            step(m, 1'b0, '0, 1'b1, acc);
        end

        // Random traffic with occasional flush and reset.
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 300; i++) begin
                k = $urandom_range(0, 99);
                if (k < 3) ctl_cycle(m, 1'b1);
                else if (k < 5) ctl_cycle(m, 1'b0);
                else step(m, 1'($urandom_range(0, 1)), W'($urandom),
                          $urandom_range(0, 9) < 6, acc);
            end
            for (int i = 0; i < 3; i++) step(m, 1'b0, '0, 1'b1, acc);
            check($sformatf("m%0d drained level", m), 32'(lvl[m]), 32'd0);
            mq.delete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
